// File: rtl/time_of_day_counter_if.sv
// Bundles the tick/set-mode controls and the time-of-day outputs.
// The testbench or prescaler side drives the controls through the master modport.
// The counter consumes the controls and drives the outputs through the slave modport.
interface time_of_day_counter_if #(
    parameter int SW = 6,
    parameter int MW = 6,
    parameter int HW = 5
) ();
    logic          tick;
    logic          set;
    logic          next;
    logic          inc;
    logic [SW-1:0] sec;
    logic [MW-1:0] min;
    logic [HW-1:0] hour;
    logic [1:0]    field;
    logic          in_set;
    logic          day_carry;

    modport master (
        output tick, set, next, inc,
        input  sec, min, hour, field, in_set, day_carry
    );

    modport slave (
        input  tick, set, next, inc,
        output sec, min, hour, field, in_set, day_carry
    );
endinterface

// File: rtl/time_of_day_counter.sv
// Time-of-day counter: cascaded sec/min/hour counters advanced by the prescaler tick.
// A one-cycle day_carry pulse is produced on the 23:59:59 -> 00:00:00 wrap.
// In set mode, ticks are dropped and the user steps one selected field at a time.
// Set-mode increments never carry into a neighbouring field.
module time_of_day_counter #(
    parameter int SEC_MOD  = 60,
    parameter int MIN_MOD  = 60,
    parameter int HOUR_MOD = 24
) (
    input logic                  clock,
    input logic                  reset,
    time_of_day_counter_if.slave bus
);
    localparam int SW = $clog2(SEC_MOD);
    localparam int MW = $clog2(MIN_MOD);
    localparam int HW = $clog2(HOUR_MOD);

    localparam logic [1:0] FIELD_SEC  = 2'd0;
    localparam logic [1:0] FIELD_MIN  = 2'd1;
    localparam logic [1:0] FIELD_HOUR = 2'd2;

    typedef enum logic {
        RUN = 1'b0,
        SET = 1'b1
    } state_t;

    state_t        state;
    state_t        nextState;
    logic [SW-1:0] secQ;
    logic [SW-1:0] nextSec;
    logic [MW-1:0] minQ;
    logic [MW-1:0] nextMin;
    logic [HW-1:0] hourQ;
    logic [HW-1:0] nextHour;
    logic [1:0]    fieldQ;
    logic [1:0]    nextField;
    logic          dayCarryQ;
    logic          nextDayCarry;

    logic secAtMax;
    logic minAtMax;
    logic hourAtMax;

    // Terminal-count detection; each stage compares against MOD-1 before incrementing.
    assign secAtMax  = (secQ  == SW'(SEC_MOD - 1));
    assign minAtMax  = (minQ  == MW'(MIN_MOD - 1));
    assign hourAtMax = (hourQ == HW'(HOUR_MOD - 1));

    // Register the FSM state, counters, selected field and carry pulse; reset wins over everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= RUN;
            secQ      <= '0;
            minQ      <= '0;
            hourQ     <= '0;
            fieldQ    <= FIELD_SEC;
            dayCarryQ <= 1'b0;
        end else begin
            state     <= nextState;
            secQ      <= nextSec;
            minQ      <= nextMin;
            hourQ     <= nextHour;
            fieldQ    <= nextField;
            dayCarryQ <= nextDayCarry;
        end
    end

    // Next-state logic: single-cycle cascade in RUN, per-field stepping in SET.
    // A set transition on either edge always takes precedence over the tick.
    always_comb begin
        nextState    = state;
        nextSec      = secQ;
        nextMin      = minQ;
        nextHour     = hourQ;
        nextField    = fieldQ;
        nextDayCarry = 1'b0;

        case (state)
            RUN: begin
                nextField = FIELD_SEC;
                if (bus.set) begin
                    nextState = SET;
                end else if (bus.tick) begin
                    if (!secAtMax) begin
                        nextSec = secQ + SW'(1);
                    end else begin
                        nextSec = '0;
                        if (!minAtMax) begin
                            nextMin = minQ + MW'(1);
                        end else begin
                            nextMin = '0;
                            if (!hourAtMax) begin
                                nextHour = hourQ + HW'(1);
                            end else begin
                                nextHour     = '0;
                                nextDayCarry = 1'b1;
                            end
                        end
                    end
                end
            end

            SET: begin
                if (bus.inc) begin
                    case (fieldQ)
                        FIELD_SEC:  nextSec  = secAtMax  ? '0 : secQ  + SW'(1);
                        FIELD_MIN:  nextMin  = minAtMax  ? '0 : minQ  + MW'(1);
                        FIELD_HOUR: nextHour = hourAtMax ? '0 : hourQ + HW'(1);
                        default:    nextSec  = secQ;
                    endcase
                end
                if (bus.next) begin
                    nextField = (fieldQ == FIELD_HOUR) ? FIELD_SEC : fieldQ + 2'd1;
                end
                if (!bus.set) begin
                    nextState = RUN;
                    nextField = FIELD_SEC;
                end
            end

            default: begin
                nextState = RUN;
                nextField = FIELD_SEC;
            end
        endcase
    end

    assign bus.sec       = secQ;
    assign bus.min       = minQ;
    assign bus.hour      = hourQ;
    assign bus.field     = fieldQ;
    assign bus.in_set    = (state == SET);
    assign bus.day_carry = dayCarryQ;
endmodule

// File: tb/tb_time_of_day_counter.sv
// Scoreboard testbench for time_of_day_counter.
// The reference model keeps the time as a plain count of seconds since midnight.
// The driver pushes the expected post-edge outputs; the monitor pops them after each edge and compares.
module tb_time_of_day_counter;
    logic clock;
    logic reset;

    time_of_day_counter_if #(.SW(6), .MW(6), .HW(5)) bus ();

    time_of_day_counter #(
        .SEC_MOD  (60),
        .MIN_MOD  (60),
        .HOUR_MOD (24)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int sec;
        int min;
        int hour;
        int field;
        bit inSet;
        bit dayCarry;
        int cycle;
    } expect_t;

    expect_t expQ[$];

    int modelTime;
    int modelField;
    bit modelInSet;
    bit modelCarry;
    int checks;
    int failures;
    int cycleCount;
    bit setLevel;

    localparam int DAY_SECONDS = 24 * 3600;

    // Free-running clock, 10 time units per period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one cycle of inputs at the falling edge and push what the model expects after the next rising edge.
    task automatic applyStimulus(input bit r, input bit tk, input bit st, input bit nx, input bit ic);
        expect_t e;
        int s;
        int m;
        int h;
        @(negedge clock);
        reset    = r;
        bus.tick = tk;
        bus.set  = st;
        bus.next = nx;
        bus.inc  = ic;

        modelCarry = 1'b0;
        if (r) begin
            modelTime  = 0;
            modelField = 0;
            modelInSet = 1'b0;
        end else if (!modelInSet) begin
            modelField = 0;
            if (st) begin
                modelInSet = 1'b1;
            end else if (tk) begin
                modelTime  = (modelTime + 1) % DAY_SECONDS;
                modelCarry = (modelTime == 0);
            end
        end else begin
            s = modelTime % 60;
            m = (modelTime / 60) % 60;
            h = modelTime / 3600;
            if (ic) begin
                if (modelField == 0) s = (s + 1) % 60;
                else if (modelField == 1) m = (m + 1) % 60;
                else h = (h + 1) % 24;
            end
            modelTime = h * 3600 + m * 60 + s;
            if (nx) modelField = (modelField + 1) % 3;
            if (!st) begin
                modelInSet = 1'b0;
                modelField = 0;
            end
        end

        e.sec      = modelTime % 60;
        e.min      = (modelTime / 60) % 60;
        e.hour     = modelTime / 3600;
        e.field    = modelField;
        e.inSet    = modelInSet;
        e.dayCarry = modelCarry;
        e.cycle    = cycleCount;
        cycleCount++;
        expQ.push_back(e);
    endtask

    // Compare the DUT outputs against one scoreboard entry.
    task automatic checkOutput(input expect_t e);
        checks++;
        if (int'(bus.sec) != e.sec || int'(bus.min) != e.min || int'(bus.hour) != e.hour ||
            int'(bus.field) != e.field || bus.in_set != e.inSet || bus.day_carry != e.dayCarry) begin
            failures++;
            $display("[TB] FAIL cycle=%0d got %0d:%0d:%0d field=%0d in_set=%0b day_carry=%0b expected %0d:%0d:%0d field=%0d in_set=%0b day_carry=%0b",
                     e.cycle, bus.hour, bus.min, bus.sec, bus.field, bus.in_set, bus.day_carry,
                     e.hour, e.min, e.sec, e.field, e.inSet, e.dayCarry);
        end
    endtask

    // Monitor: after every rising edge, pop and check the entry queued for that edge.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (expQ.size() > 0) begin
                checkOutput(expQ.pop_front());
            end
        end
    end

    // Reset, then load h:m:s through set mode and return to RUN with field back on SEC.
    task automatic presetTime(input int h, input int m, input int s, input bit stayInSet);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        repeat (s) applyStimulus(0, 0, 1, 0, 1);
        applyStimulus(0, 0, 1, 1, 0);
        repeat (m) applyStimulus(0, 0, 1, 0, 1);
        applyStimulus(0, 0, 1, 1, 0);
        repeat (h) applyStimulus(0, 0, 1, 0, 1);
        if (!stayInSet) begin
            applyStimulus(0, 0, 1, 1, 0);
            applyStimulus(0, 0, 0, 0, 0);
        end
    endtask

    // Directed scenarios followed by a randomized run and a bounded scoreboard drain.
    initial begin
        reset      = 1'b1;
        bus.tick   = 1'b0;
        bus.set    = 1'b0;
        bus.next   = 1'b0;
        bus.inc    = 1'b0;
        checks     = 0;
        failures   = 0;
        cycleCount = 0;
        modelTime  = 0;
        modelField = 0;
        modelInSet = 1'b0;
        modelCarry = 1'b0;

        // Reset held with garbage on tick/inc/next.
        repeat (3) applyStimulus(1, 1'($urandom), 0, 1'($urandom), 1'($urandom));
        applyStimulus(0, 0, 0, 0, 0);

        // Second rollover into minutes.
        presetTime(0, 0, 59, 1'b0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        // Full day wrap with a single-cycle carry.
        presetTime(23, 59, 59, 1'b0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        // Ticks dropped in set mode; 60 increments wrap sec without touching min.
        presetTime(0, 0, 59, 1'b0);
        applyStimulus(0, 1, 1, 0, 0);
        repeat (5) applyStimulus(0, 1, 1, 0, 0);
        repeat (60) applyStimulus(0, 0, 1, 0, 1);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);

        // inc and next together, then field cycles back to SEC.
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 1, 1);
        applyStimulus(0, 0, 1, 1, 0);
        applyStimulus(0, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0);

        // inc/next ignored in RUN.
        applyStimulus(0, 0, 0, 1, 1);

        // Reset while in set mode on the hour field.
        presetTime(12, 34, 56, 1'b1);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        // Randomized traffic starting near the end of the day.
        presetTime(23, 59, 30, 1'b0);
        setLevel = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 24) == 0) setLevel = ~setLevel;
            applyStimulus(($urandom_range(0, 299) == 0), 1'($urandom), setLevel,
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end
        applyStimulus(0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clock);
        #2;
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
